// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter: round-robin access to one registered bitwise gate unit; define GATE_ARB_FIXED_PRIO_EN for fixed lowest-index priority
module gate_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_out,
  output logic                     busy
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q, res;
  logic [2:0]       op_q;
  logic [IDW-1:0]   id_q, winner;
  logic             found;
`ifdef GATE_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        winner = IDW'(k);
        found  = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] last_grant;
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        winner = IDW'((int'(last_grant) + k) % NUM_REQ);
        found  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= IDW'(NUM_REQ - 1);
    else if (state == IDLE && found) last_grant <= winner;
`endif
  // Grant is suppressed while reset is asserted so req_ready reads 0 during reset.
  assign req_ready = (rst_n && state == IDLE && found) ? NUM_REQ'(1) << winner : '0;
  assign busy = state != IDLE;
  assign res = op_q == 3'd0 ? a_q & b_q :
               op_q == 3'd1 ? a_q | b_q :
               op_q == 3'd2 ? ~a_q :
               op_q == 3'd3 ? ~(a_q & b_q) :
               op_q == 3'd4 ? ~(a_q | b_q) :
               op_q == 3'd5 ? a_q ^ b_q :
               op_q == 3'd6 ? ~(a_q ^ b_q) : a_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_out   <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        a_q   <= req_a[winner*WIDTH +: WIDTH];
        b_q   <= req_b[winner*WIDTH +: WIDTH];
        op_q  <= req_op[winner*3 +: 3];
        id_q  <= winner;
        state <= EXEC;
      end
    end else if (state == EXEC) begin
      rsp_out   <= res;
      rsp_id    <= id_q;
      rsp_valid <= 1'b1;
      state     <= RESP;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
      state     <= IDLE;
    end
endmodule
